// File: rtl/shbuf_seq_ctrl_pkg.sv
// Shared definitions for the word-shift buffer sequencer: state encoding,
// default geometry and a counter-width helper.
package shbuf_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_FILL  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEF_WORDS  = 16;
  localparam int DEF_READS  = 4;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_FC_W   = 8;

  // Width needed to count 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shbuf_wrap_cnt.sv
// Enable/clear up-counter that wraps to zero after MAX and flags the terminal
// count so the owner can detect the last handshake of a phase.
module shbuf_wrap_cnt #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  localparam logic [W-1:0] LP_MAX = W'(MAX);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LP_MAX) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == LP_MAX);

endmodule

// File: rtl/shbuf_seq_ctrl.sv
// Sequencer for the 16x32-bit word-shift buffer: clear, fill from a word
// stream, then drain READS four-word groups to a consumer.
module shbuf_seq_ctrl
  import shbuf_seq_ctrl_pkg::*;
#(
  parameter int WORDS  = DEF_WORDS,
  parameter int READS  = DEF_READS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int FC_W   = DEF_FC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              buf_en,
  output logic              buf_clr,
  output logic [ADDR_W-1:0] buf_addr,
  output logic              busy,
  output logic              done,
  output logic [FC_W-1:0]   frame_cnt
);

  localparam int WC_W = cnt_w(WORDS);

  state_t            r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_buf_clr;
  logic              r_busy;
  logic              r_done;
  logic [FC_W-1:0]   r_frame_cnt;

  logic              w_in_hs;
  logic              w_out_hs;
  logic [WC_W-1:0]   w_wcnt_unused;
  logic              w_wtc;
  logic [ADDR_W-1:0] w_rcnt;
  logic              w_rtc;

  // A handshake in the abort cycle still moves the buffer but is not counted.
  assign w_in_hs  = (r_state == ST_FILL) && in_valid;
  assign w_out_hs = (r_state == ST_DRAIN) && out_ready;

  shbuf_wrap_cnt #(
    .W   (WC_W),
    .MAX (WORDS - 1)
  ) u_wcnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_in_hs && !abort),
    .i_clr (abort),
    .o_cnt (w_wcnt_unused),
    .o_tc  (w_wtc)
  );

  shbuf_wrap_cnt #(
    .W   (ADDR_W),
    .MAX (READS - 1)
  ) u_rcnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_out_hs && !abort),
    .i_clr (abort),
    .o_cnt (w_rcnt),
    .o_tc  (w_rtc)
  );

  // Moore outputs are registered alongside the state they decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_buf_clr   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
    end else if (abort) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_buf_clr   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_CLR;
            r_buf_clr <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        ST_CLR: begin
          r_state    <= ST_FILL;
          r_buf_clr  <= 1'b0;
          r_in_ready <= 1'b1;
        end
        ST_FILL: begin
          if (in_valid && w_wtc) begin
            r_state     <= ST_DRAIN;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (out_ready && w_rtc) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_buf_clr   <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign buf_en    = w_in_hs;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign buf_clr   = r_buf_clr;
  assign buf_addr  = w_rcnt;
  assign busy      = r_busy;
  assign done      = r_done;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: doc/shbuf_seq_ctrl.md
Name: shbuf_seq_ctrl

Overview:
- Controller that sequences the 512-bit word-shift buffer (16 x 32-bit words, 4-bit read address, 128-bit four-word read port).
- Fills the buffer from a streaming word source over a valid/ready handshake, then drains it as READS 128-bit groups to a consumer, stepping the buffer read address.
- Sits between the input word stream and the buffer/consumer pair. The buffer's data input and read result are wired outside this block; this block drives only the buffer's control pins and the handshakes.

Parameters:
- WORDS, 16, words shifted in per frame
- READS, 4, 128-bit groups read per frame (addr 0..READS-1); must be <=4 when WORDS=16
- ADDR_W, 4, buffer read address width
- FC_W, 8, frame counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- abort  in  1  synchronous return to IDLE from any state
- in_valid  in  1  source word valid
- in_ready  out  1  controller accepting words
- out_valid  out  1  current 128-bit group valid at buffer read port
- out_ready  in  1  consumer accepts group
- buf_en  out  1  buffer shift enable
- buf_clr  out  1  active-high buffer clear pulse
- buf_addr  out  ADDR_W  buffer read address
- busy  out  1  state != IDLE
- done  out  1  one-cycle frame-complete pulse
- frame_cnt  out  FC_W  completed frames, wraps

Behaviour:
- States: IDLE, CLR, FILL, DRAIN, DONE. Registers: state, wcnt (clog2(WORDS) bits), rcnt (ADDR_W bits), frame_cnt.
- Reset (rst=0, async): state=IDLE, wcnt=0, rcnt=0, frame_cnt=0. All outputs 0: in_ready, out_valid, buf_en, buf_clr, buf_addr, busy, done.
- IDLE: start=1 -> CLR. Otherwise stay.
- CLR (exactly 1 cycle):
  - buf_clr=1, in_ready=0.
  - Next state FILL.
- FILL:
  - in_ready=1.
  - buf_en = in_valid (combinational, FILL only).
  - Each handshake: wcnt++.
  - Handshake with wcnt==WORDS-1 -> DRAIN, wcnt=0.
  - in_valid gaps stall with no shift.
- DRAIN:
  - out_valid=1, buf_addr=rcnt, buf_en=0, so buffer contents stay frozen.
  - out_valid & out_ready: rcnt++.
  - Handshake with rcnt==READS-1 -> DONE, rcnt=0.
  - out_ready low holds buf_addr and out_valid stable.
- DONE (1 cycle):
  - done=1, frame_cnt++ (wraps 2^FC_W-1 -> 0).
  - Next state IDLE; start in this cycle is ignored.
- Latency: start to first in_ready = 2 cycles. Minimum frame = 1 + 1 + WORDS + READS + 1 cycles.
- abort=1 in any non-IDLE state:
  - Next state IDLE, wcnt=rcnt=0, no done, frame_cnt unchanged.
  - In the abort cycle, buf_en and out_valid still follow the current state. The handshake completes on the buffer side but is not counted.
- abort and start together in IDLE: abort wins; stay IDLE.
- Moore outputs (in_ready, out_valid, buf_clr, busy, done, buf_addr) decode from registers only. buf_en is the only combinational path (in_valid -> buf_en).
- Reset mid-frame: immediate IDLE. Buffer contents are the buffer's concern; the next frame's CLR clears them.

Decomposition:
- Shared package: state encoding constants (IDLE=0, CLR=1, FILL=2, DRAIN=3, DONE=4, 3-bit), default WORDS/READS/ADDR_W.
- One natural sub-module: shbuf_wrap_cnt, a parameterised enable/clear counter with terminal-count flag. It is instantiated for wcnt and rcnt. frame_cnt is inline.

Test Plan:
- Basic frame: start pulse, in_valid=1 continuously with words 0x00..0x0F, out_ready=1.
  - Required: buf_clr one cycle; exactly 16 buf_en cycles; buf_addr 0,1,2,3 on consecutive out_valid cycles.
  - Required: done one cycle later; frame_cnt=1; total 23 cycles start-to-done.
- Input bubbles: in_valid toggles 1/0 each cycle during FILL.
  - Required: buf_en only on in_valid cycles; DRAIN entered after 16th accepted word (32 FILL cycles).
- Output backpressure: out_ready=0 for 5 cycles at rcnt=2.
  - Required: buf_addr held at 2, out_valid held at 1, buf_en=0; resumes to 3 then DONE.
- Abort mid-FILL after 7 words.
  - Required: IDLE next cycle, busy=0, no done, frame_cnt unchanged.
  - Follow-up start: runs a clean 16-word frame with buf_clr.
- Async reset mid-DRAIN (rst low mid-cycle, rcnt=1).
  - Required: all outputs 0 immediately, state IDLE, frame_cnt=0.
- Back-to-back frames with FC_W=2: 5 frames, start reasserted in IDLE after each done; start held during DONE is ignored.
  - Required: frame_cnt 1,2,3,0,1.
